// File: rtl/mac_tx_arbiter_pkg.sv
// Shared types and helpers for the MAC TX frame arbiter.
package mac_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DRAIN
    } arb_state_e;

    localparam int unsigned MAX_FRAME_BEATS = 190;

    // Ceiling log2, never less than 1 so single-entry selectors still get a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mac_tx_arbiter_if.sv
// AXI-stream bundle between the frame sources, the arbiter and the MAC TX port.
interface mac_tx_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned N_REQ      = 2
);
    logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata;
    logic [N_REQ*KEEP_WIDTH-1:0] s_axis_tkeep;
    logic [N_REQ-1:0]            s_axis_tvalid;
    logic [N_REQ-1:0]            s_axis_tlast;
    logic [N_REQ-1:0]            s_axis_tuser;
    logic [N_REQ-1:0]            s_axis_tready;

    logic [DATA_WIDTH-1:0]       m_axis_tdata;
    logic [KEEP_WIDTH-1:0]       m_axis_tkeep;
    logic                        m_axis_tvalid;
    logic                        m_axis_tlast;
    logic                        m_axis_tuser;
    logic                        m_axis_tready;

    // master: the arbiter, which drives the MAC-facing stream
    modport master (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  m_axis_tready,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output m_axis_tready,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_i, wrapping.
module mac_tx_arbiter_rr_pick #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned GRANT_W = 1
) (
    input  logic [N_REQ-1:0]   req_i,
    input  logic [GRANT_W-1:0] last_i,
    output logic               any_o,
    output logic [GRANT_W-1:0] pick_o
);

    int unsigned cand;

    // Walk from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        any_o  = 1'b0;
        pick_o = '0;
        cand   = 0;
        for (int unsigned i = N_REQ; i >= 1; i--) begin
            cand = (32'(last_i) + i) % N_REQ;
            if (req_i[cand]) begin
                any_o  = 1'b1;
                pick_o = GRANT_W'(cand);
            end
        end
    end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Per-frame round-robin arbiter onto the MAC TX stream, with frame-length truncation.
// Build option MAC_TX_ARB_PRIO0_EN: requester 0 takes absolute priority in IDLE.
module mac_tx_arbiter
    import mac_tx_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = 8,
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned GRANT_W    = 1,
    parameter int unsigned MAX_BEATS  = MAX_FRAME_BEATS
) (
    input  logic               clk,
    input  logic               resetn,
    mac_tx_arbiter_if.master   axis,
    output logic [GRANT_W-1:0] grant_id,
    output logic               busy,
    output logic               trunc_event
);

    localparam int unsigned CNT_W = clog2(MAX_BEATS + 1);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trunc_q, trunc_d;

    logic [N_REQ-1:0]   rr_req;
    logic               rr_any;
    logic [GRANT_W-1:0] rr_idx;
    logic               start;
    logic [GRANT_W-1:0] pick;
    logic               upd_last;

`ifdef MAC_TX_ARB_PRIO0_EN
    always_comb begin
        rr_req    = axis.s_axis_tvalid;
        rr_req[0] = 1'b0;
    end
    assign start    = axis.s_axis_tvalid[0] | rr_any;
    assign pick     = axis.s_axis_tvalid[0] ? '0 : rr_idx;
    assign upd_last = ~axis.s_axis_tvalid[0];
`else
    assign rr_req   = axis.s_axis_tvalid;
    assign start    = rr_any;
    assign pick     = rr_idx;
    assign upd_last = 1'b1;
`endif

    mac_tx_arbiter_rr_pick #(
        .N_REQ   (N_REQ),
        .GRANT_W (GRANT_W)
    ) u_rr_pick (
        .req_i  (rr_req),
        .last_i (last_q),
        .any_o  (rr_any),
        .pick_o (rr_idx)
    );

    int unsigned           g_idx;
    logic [DATA_WIDTH-1:0] g_data;
    logic [KEEP_WIDTH-1:0] g_keep;
    logic                  g_valid, g_last, g_user;
    logic                  at_limit, force_end;

    always_comb begin
        g_idx   = 32'(grant_q);
        g_data  = axis.s_axis_tdata[g_idx*DATA_WIDTH +: DATA_WIDTH];
        g_keep  = axis.s_axis_tkeep[g_idx*KEEP_WIDTH +: KEEP_WIDTH];
        g_valid = axis.s_axis_tvalid[grant_q];
        g_last  = axis.s_axis_tlast[grant_q];
        g_user  = axis.s_axis_tuser[grant_q];
    end

    assign at_limit  = (cnt_q == CNT_W'(MAX_BEATS - 1));
    assign force_end = at_limit & ~g_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GRANT_W'(N_REQ - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        grant_d            = grant_q;
        last_d             = last_q;
        cnt_d              = cnt_q;
        trunc_d            = 1'b0;
        axis.s_axis_tready = '0;
        axis.m_axis_tdata  = '0;
        axis.m_axis_tkeep  = '0;
        axis.m_axis_tvalid = 1'b0;
        axis.m_axis_tlast  = 1'b0;
        axis.m_axis_tuser  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    grant_d = pick;
                    if (upd_last) last_d = pick;
                    cnt_d   = '0;
                    state_d = ST_PASS;
                end
            end
            ST_PASS: begin
                axis.m_axis_tdata           = g_data;
                axis.m_axis_tkeep           = g_keep;
                axis.m_axis_tvalid          = g_valid;
                axis.m_axis_tlast           = g_last | force_end;
                axis.m_axis_tuser           = g_user | force_end;
                axis.s_axis_tready[grant_q] = axis.m_axis_tready;
                if (g_valid && axis.m_axis_tready) begin
                    if (g_last) begin
                        state_d = ST_IDLE;
                    end else if (at_limit) begin
                        trunc_d = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // The MAC already saw an abort-tagged end; swallow the rest of the source frame.
                axis.s_axis_tready[grant_q] = 1'b1;
                if (g_valid && g_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign trunc_event = trunc_q;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Scoreboard bench for mac_tx_arbiter: per-source expected queues plus a frame-level arbitration model.
module tb_mac_tx_arbiter;

    localparam int N_REQ = 2;
    localparam int MAX_B = 4;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        user;
        logic        trunc;
    } beat_t;

    logic       clk;
    logic       resetn;
    logic [0:0] grant_id;
    logic       busy;
    logic       trunc_event;

    mac_tx_arbiter_if #(.DATA_WIDTH(64), .KEEP_WIDTH(8), .N_REQ(N_REQ)) bus ();

    mac_tx_arbiter #(
        .DATA_WIDTH (64),
        .KEEP_WIDTH (8),
        .N_REQ      (N_REQ),
        .GRANT_W    (1),
        .MAX_BEATS  (MAX_B)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .axis        (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .trunc_event (trunc_event)
    );

    logic [63:0] drv_data  [N_REQ];
    logic [7:0]  drv_keep  [N_REQ];
    logic        drv_valid [N_REQ];
    logic        drv_last  [N_REQ];
    logic        drv_user  [N_REQ];

    always_comb begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tkeep  = '0;
        bus.s_axis_tvalid = '0;
        bus.s_axis_tlast  = '0;
        bus.s_axis_tuser  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.s_axis_tdata[i*64 +: 64] = drv_data[i];
            bus.s_axis_tkeep[i*8 +: 8]   = drv_keep[i];
            bus.s_axis_tvalid[i]         = drv_valid[i];
            bus.s_axis_tlast[i]          = drv_last[i];
            bus.s_axis_tuser[i]          = drv_user[i];
        end
    end

    int    n_checks = 0;
    int    n_err    = 0;
    int    mode     = 0;   // m_tready: 0 always, 1 random, 2 toggle
    bit    raw      = 0;
    beat_t exp_q [N_REQ][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic int rr_next(input logic [N_REQ-1:0] v, input int from);
        for (int k = 1; k <= N_REQ; k++)
            if (v[(from + k) % N_REQ]) return (from + k) % N_REQ;
        return 0;
    endfunction

    initial begin
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.m_axis_tready = 1'b1;
                1:       bus.m_axis_tready = 1'($urandom_range(1, 0));
                default: bus.m_axis_tready = ~bus.m_axis_tready;
            endcase
        end
    end

    // Frame-level monitor: idle -> frame -> (discarding) -> idle, arbitration from the RR rule.
    int ph = 0;
    int cur = 0;
    int lastg = N_REQ - 1;
    bit trunc_pend = 0;

    initial begin : monitor
        beat_t e;
        int    pk;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                ph = 0; cur = 0; lastg = N_REQ - 1; trunc_pend = 0;
                continue;
            end
            if (raw) continue;
            chk("busy", busy, ph != 0);
            chk("trunc_event", trunc_event, trunc_pend);
            trunc_pend = 0;
            chk("grant_id", grant_id, cur);
            case (ph)
                0: begin
                    chk("idle_m_tvalid", bus.m_axis_tvalid, 0);
                    chk("idle_s_tready", bus.s_axis_tready, 0);
                    if (|bus.s_axis_tvalid) begin
`ifdef MAC_TX_ARB_PRIO0_EN
                        pk = bus.s_axis_tvalid[0] ? 0 : rr_next(bus.s_axis_tvalid, lastg);
                        if (pk != 0) lastg = pk;
`else
                        pk = rr_next(bus.s_axis_tvalid, lastg);
                        lastg = pk;
`endif
                        cur = pk;
                        ph  = 1;
                    end
                end
                1: begin
                    chk("m_tvalid", bus.m_axis_tvalid, bus.s_axis_tvalid[cur]);
                    chk("s_tready_grant", bus.s_axis_tready[cur], bus.m_axis_tready);
                    chk("s_tready_other", bus.s_axis_tready[1 - cur], 0);
                    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                        if (exp_q[cur].size() == 0) begin
                            timeout_fail("unexpected_beat");
                            if (bus.m_axis_tlast) ph = 0;
                        end else begin
                            e = exp_q[cur].pop_front();
                            chk("tdata", bus.m_axis_tdata, e.data);
                            chk("tkeep", bus.m_axis_tkeep, e.keep);
                            chk("tlast", bus.m_axis_tlast, e.last);
                            chk("tuser", bus.m_axis_tuser, e.user);
                            if (e.last) begin
                                ph = e.trunc ? 2 : 0;
                                trunc_pend = e.trunc;
                            end
                        end
                    end
                end
                default: begin
                    chk("drain_m_tvalid", bus.m_axis_tvalid, 0);
                    chk("drain_s_tready", bus.s_axis_tready[cur], 1);
                    chk("drain_other", bus.s_axis_tready[1 - cur], 0);
                    if (bus.s_axis_tvalid[cur] && bus.s_axis_tlast[cur]) ph = 0;
                end
            endcase
        end
    end

    task automatic send_frame(input int r, input int len, input int gap, input int stall_at);
        beat_t src[$];
        beat_t e;
        int    idle;
        int    budget;
        bit    hs;
        for (int b = 0; b < len; b++) begin
            e.data  = {$urandom, $urandom};
            e.last  = (b == len - 1);
            e.keep  = e.last ? 8'($urandom_range(255, 1)) : 8'hFF;
            e.user  = e.last ? 1'($urandom_range(1, 0)) : 1'b0;
            e.trunc = 1'b0;
            src.push_back(e);
            if (b < MAX_B) begin
                if (len > MAX_B && b == MAX_B - 1) begin
                    e.last = 1'b1; e.user = 1'b1; e.trunc = 1'b1;
                end
                exp_q[r].push_back(e);
            end
        end
        for (int b = 0; b < len; b++) begin
            idle = (b == stall_at) ? 10 : int'($urandom_range(gap, 0));
            drv_valid[r] = 1'b0;
            repeat (idle) begin @(posedge clk); #1; end
            drv_data[r]  = src[b].data;
            drv_keep[r]  = src[b].keep;
            drv_last[r]  = src[b].last;
            drv_user[r]  = src[b].user;
            drv_valid[r] = 1'b1;
            hs = 0;
            budget = 0;
            while (!hs && budget < 3000) begin
                @(negedge clk);
                hs = bus.s_axis_tready[r];
                @(posedge clk);
                #1;
                budget++;
            end
            if (!hs) begin
                timeout_fail("source_handshake");
                drv_valid[r] = 1'b0;
                return;
            end
        end
        drv_valid[r] = 1'b0;
        drv_last[r]  = 1'b0;
        drv_user[r]  = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && !busy;
        end
        if (!done) timeout_fail("wait_idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        for (int i = 0; i < N_REQ; i++) begin
            drv_data[i] = '0; drv_keep[i] = '0; drv_valid[i] = 0; drv_last[i] = 0; drv_user[i] = 0;
        end
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_trunc", trunc_event, 0);
        chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("rst_s_tready", bus.s_axis_tready, 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // simultaneous 3-beat frames
        mode = 0;
        fork
            send_frame(0, 3, 0, -1);
            send_frame(1, 3, 0, -1);
        join
        wait_idle();

        // alternating backpressure
        mode = 2;
        send_frame(0, 4, 0, -1);
        wait_idle();

        // both sources continuously valid
        mode = 0;
        fork
            for (int f = 0; f < 5; f++) send_frame(0, $urandom_range(MAX_B, 1), 0, -1);
            for (int f = 0; f < 5; f++) send_frame(1, $urandom_range(MAX_B, 1), 0, -1);
        join
        wait_idle();

        // truncation and its boundary
        mode = 1;
        send_frame(1, 6, 0, -1);
        wait_idle();
        send_frame(1, MAX_B, 0, -1);
        wait_idle();
        send_frame(0, MAX_B + 1, 1, -1);
        wait_idle();

        // mid-frame stall with a competitor waiting
        mode = 0;
        fork
            send_frame(0, 4, 0, 1);
            begin
                repeat (2) begin @(posedge clk); #1; end
                send_frame(1, 3, 0, -1);
            end
        join
        wait_idle();

        // random traffic
        mode = 1;
        fork
            for (int f = 0; f < 30; f++) send_frame(0, $urandom_range(7, 1), 2, -1);
            for (int f = 0; f < 30; f++) send_frame(1, $urandom_range(7, 1), 2, -1);
        join
        wait_idle();

        // asynchronous reset in the middle of a frame
        raw  = 1;
        mode = 0;
        drv_data[0] = 64'h0123_4567_89AB_CDEF; drv_keep[0] = 8'hFF;
        drv_last[0] = 1'b0; drv_user[0] = 1'b0; drv_valid[0] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = busy;
        end
        if (!seen) timeout_fail("reset_test_grant");
        chk("pre_reset_m_tvalid", bus.m_axis_tvalid, 1);
        resetn = 1'b0;
        #1;
        chk("async_rst_m_tvalid", bus.m_axis_tvalid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_s_tready", bus.s_axis_tready, 0);
        chk("async_rst_grant", grant_id, 0);
        drv_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        resetn = 1'b1;
        raw    = 0;
        @(posedge clk); #1;
        send_frame(1, 2, 0, -1);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
